// File: rtl/score_pkg.sv
// Shared types and constants for the score display: game phase, segment
// patterns and the BCD digit width.
package score_pkg;

  localparam int DIGIT_W    = 4;
  localparam int NUM_DIGITS = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    OVER = 2'd2
  } state_t;

  // Segment order is {g,f,e,d,c,b,a}, active-high.
  localparam logic [6:0] SEG_0    = 7'h3F;
  localparam logic [6:0] SEG_1    = 7'h06;
  localparam logic [6:0] SEG_2    = 7'h5B;
  localparam logic [6:0] SEG_3    = 7'h4F;
  localparam logic [6:0] SEG_4    = 7'h66;
  localparam logic [6:0] SEG_5    = 7'h6D;
  localparam logic [6:0] SEG_6    = 7'h7D;
  localparam logic [6:0] SEG_7    = 7'h07;
  localparam logic [6:0] SEG_8    = 7'h7F;
  localparam logic [6:0] SEG_9    = 7'h6F;
  localparam logic [6:0] SEG_DASH = 7'h40;
  localparam logic [6:0] SEG_OFF  = 7'h00;

  // Non-decimal nibbles show a dash so corrupt score data is visible.
  function automatic logic [6:0] bcd_seg(input logic [DIGIT_W-1:0] nib);
    case (nib)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_DASH;
    endcase
  endfunction

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD nibble to 7-segment decoder with a blanking input.
module bcd_to_7seg
  import score_pkg::*;
(
  input  logic [DIGIT_W-1:0] nibble,
  input  logic               blank,
  output logic [6:0]         seg
);

  // Blank overrides the decoded pattern.
  always_comb begin
    seg = blank ? SEG_OFF : bcd_seg(nibble);
  end

endmodule

// File: rtl/score_display.sv
// 4-digit multiplexed 7-segment driver for the packed-BCD score.
// Tracks game phase, snapshots the score at frame boundaries, keeps the
// session high score and blinks the final score after game over.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | between games; shows session high score, dp on digit 0
// PLAY  | game running; shows score captured at the last game_tick
// OVER  | game ended; final score blinks until timeout or new start
module score_display
  import score_pkg::*;
#(
  parameter int SCAN_DIV     = 1024,
  parameter int BLINK_FRAMES = 15,
  parameter int OVER_FRAMES  = 180
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        game_start,
  input  logic        game_over,
  input  logic        game_tick,
  input  logic [15:0] score,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  digit_en,
  output logic        new_record
);

  localparam int PRESC_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int FRAME_W = (OVER_FRAMES > 1) ? $clog2(OVER_FRAMES) : 1;

  localparam logic [PRESC_W-1:0] PRESC_TC     = PRESC_W'(SCAN_DIV - 1);
  localparam logic [BLINK_W-1:0] BLINK_RELOAD = BLINK_W'(BLINK_FRAMES - 1);
  localparam logic [FRAME_W-1:0] FRAME_LAST   = FRAME_W'(OVER_FRAMES - 1);

  state_t               state_q, state_d;
  logic [15:0]          snap_q, snap_d;
  logic [15:0]          high_q, high_d;
  logic                 new_record_q, new_record_d;
  logic [FRAME_W-1:0]   frame_q, frame_d;
  logic                 blink_q, blink_d;
  logic [BLINK_W-1:0]   blink_cnt_q, blink_cnt_d;
  logic [PRESC_W-1:0]   presc_q, presc_d;
  logic [1:0]           idx_q, idx_d;
  logic [6:0]           seg_q, seg_d;
  logic                 dp_q, dp_d;
  logic [3:0]           digit_en_q, digit_en_d;

  logic [15:0]          shown;
  logic [DIGIT_W-1:0]   nibble;
  logic                 lz_blank;
  logic                 blank;

  // Digit scan: prescaler wraps at SCAN_DIV-1 and advances the digit index.
  always_comb begin
    presc_d = presc_q + 1'b1;
    idx_d   = idx_q;
    if (presc_q == PRESC_TC) begin
      presc_d = '0;
      idx_d   = idx_q + 2'd1;
    end
  end

  // Game-phase FSM with snapshot, high-score and OVER timers.
  always_comb begin
    state_d      = state_q;
    snap_d       = snap_q;
    high_d       = high_q;
    new_record_d = new_record_q;
    frame_d      = frame_q;
    blink_d      = blink_q;
    blink_cnt_d  = blink_cnt_q;
    case (state_q)
      IDLE: begin
        if (game_start) begin
          state_d = PLAY;
          snap_d  = '0;
        end
      end
      PLAY: begin
        // A start coinciding with over wins, and start is a no-op in PLAY,
        // so the pair leaves the game running.
        if (game_over && !game_start) begin
          state_d     = OVER;
          snap_d      = score;
          frame_d     = '0;
          blink_d     = 1'b0;
          blink_cnt_d = BLINK_RELOAD;
          if (score > high_q) begin
            high_d       = score;
            new_record_d = 1'b1;
          end else begin
            new_record_d = 1'b0;
          end
        end else if (game_tick) begin
          snap_d = score;
        end
      end
      OVER: begin
        if (game_start) begin
          state_d      = PLAY;
          snap_d       = '0;
          new_record_d = 1'b0;
        end else if (game_tick) begin
          if (frame_q == FRAME_LAST) begin
            state_d      = IDLE;
            new_record_d = 1'b0;
            blink_d      = 1'b0;
          end else begin
            frame_d = frame_q + 1'b1;
            if (blink_cnt_q == '0) begin
              blink_d     = ~blink_q;
              blink_cnt_d = BLINK_RELOAD;
            end else begin
              blink_cnt_d = blink_cnt_q - 1'b1;
            end
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Select the shown value and digit, then work out blanking.
  always_comb begin
    shown = (state_q == IDLE) ? high_q : snap_q;
    case (idx_q)
      2'd0:    nibble = shown[3:0];
      2'd1:    nibble = shown[7:4];
      2'd2:    nibble = shown[11:8];
      default: nibble = shown[15:12];
    endcase
    case (idx_q)
      2'd0:    lz_blank = 1'b0;
      2'd1:    lz_blank = (shown[15:4] == 12'h000);
      2'd2:    lz_blank = (shown[15:8] == 8'h00);
      default: lz_blank = (shown[15:12] == 4'h0);
    endcase
    blank      = lz_blank || ((state_q == OVER) && blink_q);
    dp_d       = (state_q == IDLE) && (idx_q == 2'd0) && !blank;
    digit_en_d = 4'b0001 << idx_q;
  end

  bcd_to_7seg u_dec (
    .nibble (nibble),
    .blank  (blank),
    .seg    (seg_d)
  );

  // State, datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      snap_q       <= '0;
      high_q       <= '0;
      new_record_q <= 1'b0;
      frame_q      <= '0;
      blink_q      <= 1'b0;
      blink_cnt_q  <= BLINK_RELOAD;
      presc_q      <= '0;
      idx_q        <= 2'd0;
      seg_q        <= SEG_OFF;
      dp_q         <= 1'b0;
      digit_en_q   <= 4'b0000;
    end else begin
      state_q      <= state_d;
      snap_q       <= snap_d;
      high_q       <= high_d;
      new_record_q <= new_record_d;
      frame_q      <= frame_d;
      blink_q      <= blink_d;
      blink_cnt_q  <= blink_cnt_d;
      presc_q      <= presc_d;
      idx_q        <= idx_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      digit_en_q   <= digit_en_d;
    end
  end

  assign seg        = seg_q;
  assign dp         = dp_q;
  assign digit_en   = digit_en_q;
  assign new_record = new_record_q;

endmodule
